dmem_arbiter: RTL and testbench

//  Two-port arbiter sharing the single-ported data memory between the pipeline
//  MEM stage (port 0) and the loader/debug DMA port (port 1). Each requester uses
//  a req/ack handshake; the arbiter serialises accesses, registers the winning

---
 rtl/dmem_arbiter.sv | 109 ++++++++++
 tb/tb_dmem_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - req/ack arbiter sharing one data memory between two ports.
// Define DMEM_ARB_FIXED_PRIO_EN to give port 0 every tie; default is round-robin.
module dmem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t state, state_next;
  logic   owner;
  logic   last;
  logic   elig0, elig1;
  logic   tie_port;
  logic   grant_valid;
  logic   grant_port;

  // The port being acknowledged in RESP is dropping its req, so it cannot win again.
  always_comb begin
    elig0 = req0 && !(state == RESP && owner == 1'b0);
    elig1 = req1 && !(state == RESP && owner == 1'b1);
`ifdef DMEM_ARB_FIXED_PRIO_EN
    tie_port = 1'b0;
`else
    tie_port = ~last;
`endif
    grant_valid = (state != ACCESS) && (elig0 || elig1);
    grant_port  = (elig0 && elig1) ? tie_port : elig1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = grant_valid ? ACCESS : IDLE;
      ACCESS:  state_next = RESP;
      RESP:    state_next = grant_valid ? ACCESS : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner          <= 1'b0;
      last           <= 1'b1;
      ack0           <= 1'b0;
      ack1           <= 1'b0;
      rdata0         <= '0;
      rdata1         <= '0;
      mem_address    <= '0;
      mem_write_data <= '0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
    end else begin
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      if (grant_valid) begin
        owner          <= grant_port;
        mem_address    <= grant_port ? addr1 : addr0;
        mem_write_data <= grant_port ? wdata1 : wdata0;
        mem_write      <= grant_port ? we1 : we0;
        mem_read       <= grant_port ? !we1 : !we0;
      end
      // mem_write still holds the latched command direction during ACCESS.
      if (state == ACCESS) begin
        if (owner) begin
          ack1 <= 1'b1;
          if (!mem_write) rdata1 <= mem_read_data;
        end else begin
          ack0 <= 1'b1;
          if (!mem_write) rdata0 <= mem_read_data;
        end
        last <= owner;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter.
module tb_dmem_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1, we0, we1;
  logic [7:0] addr0, addr1, wdata0, wdata1;
  logic       ack0, ack1;
  logic [7:0] rdata0, rdata1;
  logic [7:0] mem_address, mem_write_data, mem_read_data;
  logic       mem_read, mem_write, busy;

  logic [7:0]   mem [256];
  logic [255:0] wr_valid = '0;

  int errors = 0;
  int checks = 0;

  dmem_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_read_data(mem_read_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // Unwritten locations read back as addr ^ 0xC3.
  always @(posedge clk) begin
    if (mem_write) begin
      mem[mem_address]      <= mem_write_data;
      wr_valid[mem_address] <= 1'b1;
    end
  end
  assign mem_read_data = wr_valid[mem_address] ? mem[mem_address] : (mem_address ^ 8'hC3);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    do_reset();
    check("rst_busy", busy, 0);
    check("rst_ack", {ack0, ack1}, 0);
    check("rst_mem_ctl", {mem_read, mem_write}, 0);
    check("rst_rdata", {rdata0, rdata1}, 0);

    // 1: reset cuts a write mid-ACCESS
    req0 = 1; we0 = 1; addr0 = 8'h64; wdata0 = 8'hAA;
    tick();
    check("t1_access_wr", mem_write, 1);
    check("t1_access_addr", mem_address, 8'h64);
    #1 rst = 1'b1;
    #1;
    check("t1_async_wr", mem_write, 0);
    check("t1_async_addr", mem_address, 0);
    check("t1_async_wdata", mem_write_data, 0);
    check("t1_async_busy", busy, 0);
    req0 = 0; we0 = 0;
    tick();
    rst = 1'b0;
    req0 = 1; we0 = 0; addr0 = 8'h64;
    tick();
    check("t1_rd_access", mem_read, 1);
    tick();
    check("t1_rd_ack", ack0, 1);
    check("t1_rd_data", rdata0, 8'hA7);
    req0 = 0;
    tick();

    // 2: write then read back on port 0
    req0 = 1; we0 = 1; addr0 = 8'h64; wdata0 = 8'h5A;
    tick();
    check("t2_wr_access", {mem_write, mem_read}, 2'b10);
    check("t2_wr_wdata", mem_write_data, 8'h5A);
    check("t2_wr_noack", ack0, 0);
    tick();
    check("t2_wr_ack", ack0, 1);
    check("t2_wr_memoff", mem_write, 0);
    req0 = 0;
    tick();
    check("t2_idle_ack", ack0, 0);
    req0 = 1; we0 = 0;
    tick();
    check("t2_rd_access", {mem_write, mem_read}, 2'b01);
    tick();
    check("t2_rd_ack", ack0, 1);
    check("t2_rd_data", rdata0, 8'h5A);
    req0 = 0;
    tick();

    // 3: simultaneous reads after reset, port 0 first, no idle gap
    do_reset();
    req0 = 1; we0 = 0; addr0 = 8'h65;
    req1 = 1; we1 = 0; addr1 = 8'h66;
    tick();
    check("t3_c1_addr", mem_address, 8'h65);
    tick();
    check("t3_c2_ack", {ack0, ack1}, 2'b10);
    check("t3_c2_rdata0", rdata0, 8'hA6);
    req0 = 0;
    tick();
    check("t3_c3_busy", busy, 1);
    check("t3_c3_addr", mem_address, 8'h66);
    check("t3_c3_read", mem_read, 1);
    tick();
    check("t3_c4_ack", {ack0, ack1}, 2'b01);
    check("t3_c4_rdata1", rdata1, 8'hA5);
    req1 = 0;
    tick();
    check("t3_c5_busy", busy, 0);
    check("t3_c5_hold", rdata1, 8'hA5);

    // 4: both held continuously, grants alternate starting with port 0
    req0 = 1; we0 = 0; addr0 = 8'h20;
    req1 = 1; we1 = 0; addr1 = 8'h21;
    for (int c = 1; c <= 16; c++) begin
      tick();
      check($sformatf("t4_c%0d_ack0", c), ack0, (c % 4 == 2));
      check($sformatf("t4_c%0d_ack1", c), ack1, (c % 4 == 0));
      check($sformatf("t4_c%0d_busy", c), busy, 1);
    end
    check("t4_rdata0", rdata0, 8'hE3);
    check("t4_rdata1", rdata1, 8'hE2);
    req0 = 0; req1 = 0;
    tick();
    check("t4_end_idle", busy, 0);

    // 5: write on port 1, overlapping read of the same address on port 0
    req1 = 1; we1 = 1; addr1 = 8'h67; wdata1 = 8'h33;
    tick();
    check("t5_c1_wr", {mem_write, mem_read}, 2'b10);
    req0 = 1; we0 = 0; addr0 = 8'h67;
    tick();
    check("t5_c2_ack", {ack0, ack1}, 2'b01);
    check("t5_c2_memctl", {mem_write, mem_read}, 2'b00);
    req1 = 0; we1 = 0;
    tick();
    check("t5_c3_rd", {mem_write, mem_read}, 2'b01);
    tick();
    check("t5_c4_ack", {ack0, ack1}, 2'b10);
    check("t5_c4_rdata0", rdata0, 8'h33);
    check("t5_c4_memctl", {mem_write, mem_read}, 2'b00);
    req0 = 0;
    tick();

    // 6: lone port 1 read after idle
    tick();
    req1 = 1; we1 = 0; addr1 = 8'h10;
    for (int c = 1; c <= 5; c++) begin
      tick();
      check($sformatf("t6_c%0d_busy", c), busy, (c <= 2));
      check($sformatf("t6_c%0d_ack0", c), ack0, 0);
      check($sformatf("t6_c%0d_ack1", c), ack1, (c == 2));
      if (c == 2) begin
        check("t6_rdata1", rdata1, 8'hD3);
        req1 = 0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
